// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector and its upstream serializer.
package seq_det_pkg;

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   // Line level between words; detector benches use the same constant.
   localparam logic IDLE_BIT_DEFAULT = 1'b0;

   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: valid/ready word intake,
// one bit per enabled clk1 edge on sbit, back-to-back words without a bubble.
module seq_bit_serializer
   import seq_det_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             bit_en,
   output logic             sbit,
   output logic             sbit_valid,
   output logic             frame_last,
   output logic             busy
);

   localparam int            CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [WIDTH-1:0] shreg, shreg_nx;
   logic             sbit_nx, valid_nx, last_nx;
   logic             at_last, accept;

   // shreg holds the bits not yet presented, next one always at the outgoing end.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   assign busy = (state == S_SHIFT);

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_nx   = state;
      cnt_nx     = cnt;
      shreg_nx   = shreg;
      sbit_nx    = sbit;
      valid_nx   = sbit_valid;
      at_last    = (state == S_SHIFT) && (cnt == CNT_LAST);
      load_ready = (state == S_IDLE) || (at_last && bit_en);
      accept     = load_valid && load_ready;

      case (state)
         S_IDLE: begin
            sbit_nx  = IDLE_BIT;
            valid_nx = 1'b0;
         end
         S_SHIFT: begin
            if (bit_en) begin
               if (at_last) begin
                  state_nx = S_IDLE;
                  cnt_nx   = '0;
                  shreg_nx = '0;
                  sbit_nx  = IDLE_BIT;
                  valid_nx = 1'b0;
               end else begin
                  cnt_nx   = cnt + CW'(1);
                  shreg_nx = drop_bit(shreg);
                  sbit_nx  = first_bit(shreg);
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // A same-edge accept overrides retirement, giving gap-free back-to-back words.
      if (accept) begin
         state_nx = S_SHIFT;
         cnt_nx   = '0;
         shreg_nx = drop_bit(load_data);
         sbit_nx  = first_bit(load_data);
         valid_nx = 1'b1;
      end

      last_nx = (state_nx == S_SHIFT) && (cnt_nx == CNT_LAST);
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         shreg      <= '0;
         sbit       <= IDLE_BIT;
         sbit_valid <= 1'b0;
         frame_last <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         shreg      <= shreg_nx;
         sbit       <= sbit_nx;
         sbit_valid <= valid_nx;
         frame_last <= last_nx;
      end
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB- and LSB-first instances share stimulus.
module tb_seq_bit_serializer;

   logic       clk1 = 1'b0;
   logic       rst;
   logic [7:0] load_data;
   logic       load_valid;
   logic       bit_en;
   logic       load_ready, sbit, sbit_valid, frame_last, busy;
   logic       l_load_ready, l_sbit, l_sbit_valid, l_frame_last, l_busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk1 = ~clk1;

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
      .clk1(clk1), .rst(rst), .load_data(load_data), .load_valid(load_valid),
      .load_ready(load_ready), .bit_en(bit_en), .sbit(sbit), .sbit_valid(sbit_valid),
      .frame_last(frame_last), .busy(busy)
   );

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
      .clk1(clk1), .rst(rst), .load_data(load_data), .load_valid(load_valid),
      .load_ready(l_load_ready), .bit_en(bit_en), .sbit(l_sbit), .sbit_valid(l_sbit_valid),
      .frame_last(l_frame_last), .busy(l_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   task automatic check_msb(input string tag, input int k, input logic exp_sbit,
                            input logic exp_valid, input logic exp_last, input logic exp_ready);
      check($sformatf("%s_sbit_c%0d", tag, k), sbit, exp_sbit);
      check($sformatf("%s_valid_c%0d", tag, k), sbit_valid, exp_valid);
      check($sformatf("%s_last_c%0d", tag, k), frame_last, exp_last);
      check($sformatf("%s_busy_c%0d", tag, k), busy, exp_valid);
      check($sformatf("%s_ready_c%0d", tag, k), load_ready, exp_ready);
   endtask

   // One word with bit_en held high; cycle k is the k-th cycle after the accept edge.
   task automatic serialize(input string tag, input logic [7:0] w);
      bit_en     = 1'b1;
      load_data  = w;
      load_valid = 1'b1;
      #1;
      check({tag, "_ready_idle"}, load_ready, 1'b1);
      step();
      load_valid = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         #1;
         if (k <= 8) begin
            check_msb(tag, k, w[8-k], 1'b1, k == 8, k == 8);
            check($sformatf("%s_lsb_c%0d", tag, k), l_sbit, w[k-1]);
            check($sformatf("%s_lsb_last_c%0d", tag, k), l_frame_last, k == 8);
         end else begin
            check_msb(tag, k, 1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("%s_lsb_idle", tag), l_sbit_valid, 1'b0);
         end
         step();
      end
   endtask

   initial begin
      logic [15:0] pair;
      logic [7:0]  toggled;

      rst        = 1'b1;
      load_valid = 1'b0;
      bit_en     = 1'b0;
      load_data  = '0;
      #12;
      check("rst_sbit", sbit, 1'b0);
      check("rst_valid", sbit_valid, 1'b0);
      check("rst_last", frame_last, 1'b0);
      check("rst_busy", busy, 1'b0);
      @(negedge clk1);
      rst = 1'b0;
      step();
      check("post_rst_ready", load_ready, 1'b1);

      // Single word, both bit orders.
      serialize("b4", 8'hB4);

      // Back-to-back A5 then 3C with load_valid held; data changes right after the first accept.
      pair       = 16'hA53C;
      bit_en     = 1'b1;
      load_data  = 8'hA5;
      load_valid = 1'b1;
      step();
      load_data = 8'h3C;
      for (int k = 1; k <= 17; k++) begin
         if (k == 9) load_valid = 1'b0;
         #1;
         if (k <= 16)
            check_msb("b2b", k, pair[16-k], 1'b1, (k == 8) || (k == 16), (k == 8) || (k == 16));
         else
            check_msb("b2b", k, 1'b0, 1'b0, 1'b0, 1'b1);
         step();
      end

      // Bit strobe every other cycle: each bit held for two cycles.
      toggled    = 8'hF0;
      load_data  = toggled;
      load_valid = 1'b1;
      bit_en     = 1'b1;
      step();
      load_valid = 1'b0;
      for (int j = 1; j <= 17; j++) begin
         bit_en = (j % 2 == 0) || (j == 17);
         #1;
         if (j <= 16)
            check_msb("tog", j, toggled[7-(j-1)/2], 1'b1, (j == 15) || (j == 16), j == 16);
         else
            check_msb("tog", j, 1'b0, 1'b0, 1'b0, 1'b1);
         step();
      end

      // Reset pulse mid-frame at cnt==3, then a clean word.
      bit_en     = 1'b1;
      load_data  = 8'hFF;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      step();
      step();
      step();
      #1;
      check("mid_sbit_before", sbit, 1'b1);
      rst = 1'b1;
      #1;
      check("mid_rst_sbit", sbit, 1'b0);
      check("mid_rst_valid", sbit_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_last", frame_last, 1'b0);
      check("mid_rst_lsb_valid", l_sbit_valid, 1'b0);
      @(negedge clk1);
      rst = 1'b0;
      step();
      serialize("after_rst", 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
